// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), NUM_RD
// combinational read ports with optional same-cycle bypass, and a clear sequencer.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  // Register 0 is not stored; its reads are forced to zero below.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= FIRST_ADDR;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + FIRST_ADDR;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = FIRST_ADDR;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = FIRST_ADDR;
      end
    endcase
  end

  assign ready = (state == READY);

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_cnt] <= '0;
      end else begin
        if (we0 && (waddr0 != '0)) begin
          regs[waddr0] <= wdata0;
        end
        if (we1 && (waddr1 != '0)) begin
          regs[waddr1] <= wdata1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if ((state == READY) && re[i] && (ra != '0)) begin
        if ((BYPASS != 0) && we1 && (waddr1 == ra)) begin
          rd = wdata1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == ra)) begin
          rd = wdata0;
        end else begin
          rd = regs[ra];
        end
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clr_req = 1'b0;
  logic           we0 = 1'b0;
  logic [AW-1:0]  waddr0 = '0;
  logic [DW-1:0]  wdata0 = '0;
  logic           we1 = 1'b0;
  logic [AW-1:0]  waddr1 = '0;
  logic [DW-1:0]  wdata1 = '0;
  logic [NR-1:0]  re = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata_b;
  logic [NR*DW-1:0] rdata_n;
  logic           ready_b;
  logic           ready_n;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(ready_b && ready_n) && n < 200) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [DW-1:0] rd_b(input int p);
    return rdata_b[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_n(input int p);
    return rdata_n[p*DW +: DW];
  endfunction

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    raddr = {a1, a0};
    re    = en;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    // Reset clear timing
    do_reset();
    check_eq("rst_ready0", 32'(ready_b), 32'd0);
    set_rd(5'd5, 5'd5, 2'b11);
    #1;
    check_eq("rst_rd_clear", rd_b(0) | rd_b(1), 32'd0);
    wait_ready(n);
    check_eq("rst_clear_len", 32'(n), 32'd31);
    check_eq("rst_ready1_nb", 32'(ready_n), 32'd1);

    // Fill every register, then reset must wipe them all
    for (int a = 1; a < 32; a++) begin
      we0 = 1'b1; waddr0 = AW'(a); wdata0 = 32'hA5A5A5A5;
      tick();
    end
    we0 = 1'b0;
    set_rd(5'd17, 5'd31, 2'b11);
    #1;
    check_eq("fill_r17", rd_b(0), 32'hA5A5A5A5);
    check_eq("fill_r31_nb", rd_n(1), 32'hA5A5A5A5);
    do_reset();
    wait_ready(n);
    check_eq("rst2_clear_len", 32'(n), 32'd31);
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(a), 2'b11);
      #1;
      check_eq("rst2_zero", rd_b(0) | rd_b(1) | rd_n(0) | rd_n(1), 32'd0);
    end

    // Bypass vs no bypass
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    set_rd(5'd5, 5'd0, 2'b01);
    #1;
    check_eq("byp_same", rd_b(0), 32'hDEADBEEF);
    check_eq("nobyp_same", rd_n(0), 32'd0);
    tick();
    we0 = 1'b0;
    #1;
    check_eq("byp_next", rd_b(0), 32'hDEADBEEF);
    check_eq("nobyp_next", rd_n(0), 32'hDEADBEEF);

    // Dual-write collision and independent writes
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    set_rd(5'd7, 5'd7, 2'b11);
    #1;
    check_eq("coll_byp", rd_b(1), 32'h22222222);
    check_eq("coll_nobyp", rd_n(0), 32'd0);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    check_eq("coll_store", rd_b(0), 32'h22222222);
    check_eq("coll_store_nb", rd_n(1), 32'h22222222);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33333333;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44444444;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    set_rd(5'd3, 5'd4, 2'b11);
    #1;
    check_eq("dual_r3", rd_n(0), 32'h33333333);
    check_eq("dual_r4", rd_n(1), 32'h44444444);

    // Zero register and read enables
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0, 2'b11);
    #1;
    check_eq("r0_byp", rd_b(0), 32'd0);
    tick();
    we0 = 1'b0;
    #1;
    check_eq("r0_after", rd_b(1) | rd_n(0), 32'd0);
    set_rd(5'd0, 5'd3, 2'b01);
    #1;
    check_eq("re_off", rd_b(1), 32'd0);
    set_rd(5'd0, 5'd3, 2'b10);
    #1;
    check_eq("re_on", rd_b(1), 32'h33333333);

    // clr_req mid-stream
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h00001234;
    tick();
    waddr0 = 5'd10; wdata0 = 32'h00000055; clr_req = 1'b1;
    tick();
    we0 = 1'b0; clr_req = 1'b0;
    check_eq("clr_ready0", 32'(ready_b), 32'd0);
    check_eq("clr_r10_commit", dut.regs[10], 32'h00000055);
    check_eq("clr_r9_kept", dut.regs[9], 32'h00001234);
    set_rd(5'd9, 5'd10, 2'b11);
    #1;
    check_eq("clr_rd_zero", rd_b(0) | rd_b(1), 32'd0);
    for (int k = 0; k < 15; k++) tick();
    we0 = 1'b1; waddr0 = 5'd11; wdata0 = 32'h00000077; clr_req = 1'b1;
    tick();
    we0 = 1'b0; clr_req = 1'b0;
    wait_ready(n);
    check_eq("clr_rest_len", 32'(n), 32'd15);
    set_rd(5'd9, 5'd10, 2'b11);
    #1;
    check_eq("clr_r9_r10", rd_b(0) | rd_b(1), 32'd0);
    set_rd(5'd11, 5'd7, 2'b11);
    #1;
    check_eq("clr_r11_drop", rd_b(0), 32'd0);
    check_eq("clr_r7", rd_n(1), 32'd0);

    // Reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check_eq("mid_ready0", 32'(ready_b), 32'd0);
    do_reset();
    check_eq("mid_cnt1", 32'(dut.clr_cnt), 32'd1);
    wait_ready(n);
    check_eq("mid_clear_len", 32'(n), 32'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
